tlb_multiport: RTL and testbench

//  Parametrised joint TLB for the MMU; replaces the fixed 2-lookup-port TLB.

---
 rtl/tlb_multiport.sv | 214 +++++++++++++++++++++
 tb/tb_tlb_multiport.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_multiport.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tlb_multiport (with package tlb_pkg)                       |
// | Description : Joint MMU TLB with NPORTS registered lookup channels, a    |
// |               registered TLBP probe, combinational TLBR read, TLBWI /    |
// |               TLBWR writes with a Wired-aware Random counter, and a      |
// |               full flush. 4 KB pages only.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk, rst_n      clock, asynchronous active-low reset                   |
// |   asid            ASID used by the lookup channels                       |
// |   lk_req/vaddr    per-channel lookup request and virtual address         |
// |   lk_rsp_valid    per-channel response strobe (one cycle after lk_req)   |
// |   lk_result       per-channel {miss, which, pfn[19:0], c[2:0], d, v}     |
// |   rw_index        TLBR / TLBWI index; rw_rdata = entries[rw_index]       |
// |   wi_we / wr_we   indexed / random write strobes, wdata = new entry      |
// |   wired/wired_we  CP0 Wired value and its write strobe                   |
// |   random          CP0 Random value                                       |
// |   probe_*         TLBP request, EntryHi, result strobe and Index value   |
// |   flush           clear V0/V1/G of every entry                           |
// |   multi_hit       sticky multiple-match indicator, cleared by flush      |
// +--------------------------------------------------------------------------+

package tlb_pkg;
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;
endpackage

module tlb_multiport
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int NPORTS  = 2,
    localparam int IW     = $clog2(ENTRIES),
    localparam int RW     = IW + 26
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             asid,
    input  logic [NPORTS-1:0]      lk_req,
    input  logic [NPORTS*32-1:0]   lk_vaddr,
    output logic [NPORTS-1:0]      lk_rsp_valid,
    output logic [NPORTS*RW-1:0]   lk_result,
    input  logic [IW-1:0]          rw_index,
    output tlb_entry_t             rw_rdata,
    input  logic                   wi_we,
    input  logic                   wr_we,
    input  tlb_entry_t             wdata,
    input  logic [IW-1:0]          wired,
    input  logic                   wired_we,
    output logic [IW-1:0]          random,
    input  logic                   probe_req,
    input  logic [31:0]            probe_hi,
    output logic                   probe_valid,
    output logic [31:0]            probe_index,
    input  logic                   flush,
    output logic                   multi_hit
);

    localparam logic [IW-1:0] C_TOP = IW'(ENTRIES - 1);

    tlb_entry_t        r_entries [ENTRIES];
    logic [IW-1:0]     r_random;
    logic              r_multi;
    logic              r_probe_valid;
    logic [31:0]       r_probe_index;
    logic [NPORTS-1:0] w_port_multi;
    logic [RW:0]       w_probe_m;
    logic [24:0]       w_unused_probe;

    // Associative search. Returns {multi, miss, which, pfn, c, d, v}.
    // Lowest matching index wins; on a miss, which is 0 and the half of
    // entry 0 is returned (the caller only looks at miss in that case).
    // V bits are deliberately not part of the match: an invalid match is a
    // hit whose v=0 lets the downstream logic raise the invalid fault.
    function automatic logic [RW:0] match(input logic [31:0] va, input logic [7:0] id);
        logic          hit;
        logic          multi;
        logic [IW-1:0] which;
        tlb_entry_t    e;
        hit   = 1'b0;
        multi = 1'b0;
        which = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_entries[i].vpn2 == va[31:13] && (r_entries[i].g || r_entries[i].asid == id)) begin
                if (hit) begin
                    multi = 1'b1;
                end else begin
                    hit   = 1'b1;
                    which = IW'(i);
                end
            end
        end
        e = r_entries[which];
        if (va[12]) begin
            return {multi, ~hit, which, e.pfn1, e.c1, e.d1, e.v1};
        end
        return {multi, ~hit, which, e.pfn0, e.c0, e.d0, e.v0};
    endfunction

    // ---------------------------------------------------------------- lookup
    generate
        for (genvar p = 0; p < NPORTS; p++) begin : g_port
            logic [RW:0]   w_m;
            logic          r_valid;
            logic [RW-1:0] r_res;

            assign w_m             = match(lk_vaddr[p*32 +: 32], asid);
            assign w_port_multi[p] = lk_req[p] & w_m[RW];

            // Result holds its last value when no request is presented.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_res   <= '0;
                end else begin
                    r_valid <= lk_req[p];
                    if (lk_req[p]) begin
                        r_res <= w_m[RW-1:0];
                    end
                end
            end

            assign lk_rsp_valid[p]         = r_valid;
            assign lk_result[p*RW +: RW]   = r_res;
        end
    endgenerate

    // ----------------------------------------------------------------- probe
    assign w_probe_m      = match(probe_hi, probe_hi[7:0]);
    assign w_unused_probe = w_probe_m[24:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_probe_valid <= 1'b0;
            r_probe_index <= '0;
        end else begin
            r_probe_valid <= probe_req;
            if (probe_req) begin
                r_probe_index <= {w_probe_m[RW-1], {(31-IW){1'b0}}, w_probe_m[RW-2 -: IW]};
            end
        end
    end

    // ------------------------------------------------------- multi-hit flag
    // Flush clears the flag even if a same-cycle search saw several matches
    // in the pre-flush contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_multi <= 1'b0;
        end else if (flush) begin
            r_multi <= 1'b0;
        end else if ((|w_port_multi) || (probe_req && w_probe_m[RW])) begin
            r_multi <= 1'b1;
        end
    end

    // -------------------------------------------------------- random counter
    // "<=" rather than "==" also covers Wired being raised above Random and
    // pins Random at the top when Wired >= ENTRIES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_random <= C_TOP;
        end else if (wired_we || (r_random <= wired)) begin
            r_random <= C_TOP;
        end else begin
            r_random <= r_random - 1'b1;
        end
    end

    // ----------------------------------------------------------- entry array
    // Write is applied after flush so a coinciding write lands unmodified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    r_entries[i].v0 <= 1'b0;
                    r_entries[i].v1 <= 1'b0;
                    r_entries[i].g  <= 1'b0;
                end
            end
            if (wi_we) begin
                r_entries[rw_index] <= wdata;
            end else if (wr_we) begin
                r_entries[r_random] <= wdata;
            end
        end
    end

    assign rw_rdata    = r_entries[rw_index];
    assign random      = r_random;
    assign probe_valid = r_probe_valid;
    assign probe_index = r_probe_index;
    assign multi_hit   = r_multi;

endmodule

`default_nettype wire

// File: tb/tb_tlb_multiport.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tlb_multiport                                           |
// | Description : Self-checking bench for tlb_multiport (16 entries, 2 ports)|
// |               with a lookup scoreboard fed from a reference entry table. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_tlb_multiport;
    import tlb_pkg::*;

    localparam int ENTRIES = 16;
    localparam int NPORTS  = 2;
    localparam int IW      = 4;
    localparam int RW      = IW + 26;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [7:0]           asid;
    logic [NPORTS-1:0]    lk_req;
    logic [NPORTS*32-1:0] lk_vaddr;
    logic [NPORTS-1:0]    lk_rsp_valid;
    logic [NPORTS*RW-1:0] lk_result;
    logic [IW-1:0]        rw_index;
    tlb_entry_t           rw_rdata;
    logic                 wi_we;
    logic                 wr_we;
    tlb_entry_t           wdata;
    logic [IW-1:0]        wired;
    logic                 wired_we;
    logic [IW-1:0]        random;
    logic                 probe_req;
    logic [31:0]          probe_hi;
    logic                 probe_valid;
    logic [31:0]          probe_index;
    logic                 flush;
    logic                 multi_hit;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]    port;
        logic [RW-1:0] res;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_x;
    tlb_entry_t m [ENTRIES];

    tlb_multiport #(.ENTRIES(ENTRIES), .NPORTS(NPORTS)) dut (
        .clk(clk), .rst_n(rst_n), .asid(asid),
        .lk_req(lk_req), .lk_vaddr(lk_vaddr),
        .lk_rsp_valid(lk_rsp_valid), .lk_result(lk_result),
        .rw_index(rw_index), .rw_rdata(rw_rdata),
        .wi_we(wi_we), .wr_we(wr_we), .wdata(wdata),
        .wired(wired), .wired_we(wired_we), .random(random),
        .probe_req(probe_req), .probe_hi(probe_hi),
        .probe_valid(probe_valid), .probe_index(probe_index),
        .flush(flush), .multi_hit(multi_hit)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- model
    function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] a, input logic g,
                                      input logic [19:0] p0, input logic v0,
                                      input logic [19:0] p1, input logic v1);
        tlb_entry_t e;
        e.vpn2 = vpn2; e.asid = a;    e.g  = g;
        e.pfn0 = p0;   e.c0 = 3'd2;   e.d0 = 1'b0; e.v0 = v0;
        e.pfn1 = p1;   e.c1 = 3'd3;   e.d1 = 1'b1; e.v1 = v1;
        return e;
    endfunction

    function automatic logic [RW-1:0] model_lookup(input logic [31:0] va, input logic [7:0] id);
        int         first;
        tlb_entry_t e;
        first = -1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (m[i].vpn2 == va[31:13] && (m[i].g || m[i].asid == id)) first = i;
        end
        e = m[(first < 0) ? 0 : first];
        if (va[12]) return {first < 0, IW'((first < 0) ? 0 : first), e.pfn1, e.c1, e.d1, e.v1};
        return {first < 0, IW'((first < 0) ? 0 : first), e.pfn0, e.c0, e.d0, e.v0};
    endfunction

    task automatic model_flush();
        for (int i = 0; i < ENTRIES; i++) begin
            m[i].v0 = 1'b0; m[i].v1 = 1'b0; m[i].g = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
        lk_req = '0; wi_we = 1'b0; wr_we = 1'b0; flush = 1'b0; wired_we = 1'b0; probe_req = 1'b0;
    endtask

    // Drives a lookup for the next edge and records what the table holds now.
    task automatic issue(input int p, input logic [31:0] va);
        exp_t x;
        lk_req[p] = 1'b1;
        lk_vaddr[p*32 +: 32] = va;
        x.port = 2'(p);
        x.res  = model_lookup(va, asid);
        exp_q.push_back(x);
    endtask

    // ---------------------------------------------------- scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (lk_rsp_valid[p]) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected port=%0d got=%h want=none", p, lk_result[p*RW +: RW]);
                    end else begin
                        mon_x = exp_q.pop_front();
                        if (mon_x.port != 2'(p) || lk_result[p*RW +: RW] !== mon_x.res) begin
                            bad++;
                            $display("FAIL sb_result port=%0d got=%h want=%h (port %0d)",
                                     p, lk_result[p*RW +: RW], mon_x.res, mon_x.port);
                        end
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0; asid = '0; lk_req = '0; lk_vaddr = '0; rw_index = '0;
        wi_we = 1'b0; wr_we = 1'b0; wdata = '0; wired = '0; wired_we = 1'b0;
        probe_req = 1'b0; probe_hi = '0; flush = 1'b0;
        for (int i = 0; i < ENTRIES; i++) m[i] = '0;
        #12;
        total++; if (lk_rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b want=00", lk_rsp_valid); end
        total++; if (lk_result !== '0) begin bad++; $display("FAIL rst_result got=%h want=0", lk_result); end
        total++; if (probe_valid !== 1'b0 || probe_index !== 32'h0) begin bad++; $display("FAIL rst_probe got=%b/%h want=0/0", probe_valid, probe_index); end
        total++; if (multi_hit !== 1'b0) begin bad++; $display("FAIL rst_multi got=%b want=0", multi_hit); end
        total++; if (random !== 4'd15) begin bad++; $display("FAIL rst_random got=%0d want=15", random); end
        total++; if (rw_rdata !== '0) begin bad++; $display("FAIL rst_entry got=%h want=0", rw_rdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_write_lookup();
        logic [RW-1:0] want;
        wdata = mk(19'h00040, 8'd5, 1'b0, 20'h0abcd, 1'b1, 20'h12345, 1'b1);
        rw_index = 4'd3; wi_we = 1'b1;
        cyc(); m[3] = wdata;
        asid = 8'd5;
        issue(0, 32'h0008_1000);
        cyc();
        want = {1'b0, 4'd3, 20'h12345, 3'd3, 1'b1, 1'b1};
        total++; if (lk_rsp_valid !== 2'b01) begin bad++; $display("FAIL lk1_valid got=%b want=01", lk_rsp_valid); end
        total++; if (lk_result[RW-1:0] !== want) begin bad++; $display("FAIL lk1_result got=%h want=%h", lk_result[RW-1:0], want); end
        cyc();
        total++; if (lk_rsp_valid[0] !== 1'b0 || lk_result[RW-1:0] !== want) begin
            bad++; $display("FAIL lk1_hold got=%b/%h want=0/%h", lk_rsp_valid[0], lk_result[RW-1:0], want);
        end
    endtask

    task automatic test_asid_global();
        asid = 8'd6;
        issue(0, 32'h0008_1000);
        cyc();
        total++; if (lk_result[RW-1] !== 1'b1) begin bad++; $display("FAIL asid_miss got=%b want=1", lk_result[RW-1]); end
        wdata = mk(19'h00040, 8'd5, 1'b1, 20'h0abcd, 1'b1, 20'h12345, 1'b1);
        rw_index = 4'd3; wi_we = 1'b1;
        cyc(); m[3] = wdata;
        issue(0, 32'h0008_0000);
        issue(1, 32'h0008_1000);
        cyc();
        total++; if (lk_result[RW-1:0] !== {1'b0, 4'd3, 20'h0abcd, 3'd2, 1'b0, 1'b1}) begin
            bad++; $display("FAIL global_even got=%h want=%h", lk_result[RW-1:0], {1'b0, 4'd3, 20'h0abcd, 3'd2, 1'b0, 1'b1});
        end
        total++; if (lk_result[2*RW-1:RW] !== {1'b0, 4'd3, 20'h12345, 3'd3, 1'b1, 1'b1}) begin
            bad++; $display("FAIL global_odd got=%h want=%h", lk_result[2*RW-1:RW], {1'b0, 4'd3, 20'h12345, 3'd3, 1'b1, 1'b1});
        end
    endtask

    task automatic test_probe();
        probe_hi = 32'h0008_0005; probe_req = 1'b1;
        cyc();
        total++; if (probe_valid !== 1'b1 || probe_index !== 32'h0000_0003) begin
            bad++; $display("FAIL probe_hit got=%b/%h want=1/00000003", probe_valid, probe_index);
        end
        probe_hi = 32'h1234_0005; probe_req = 1'b1;
        cyc();
        total++; if (probe_index !== 32'h8000_0000) begin bad++; $display("FAIL probe_miss got=%h want=80000000", probe_index); end
        cyc();
        total++; if (probe_valid !== 1'b0) begin bad++; $display("FAIL probe_idle got=%b want=0", probe_valid); end
    endtask

    task automatic test_random();
        tlb_entry_t a;
        tlb_entry_t b;
        wired = 4'd4; wired_we = 1'b1;
        cyc();
        total++; if (random !== 4'd15) begin bad++; $display("FAIL rnd_load got=%0d want=15", random); end
        for (int k = 14; k >= 4; k--) begin
            cyc();
            total++; if (random !== 4'(k)) begin bad++; $display("FAIL rnd_seq got=%0d want=%0d", random, k); end
        end
        cyc();
        total++; if (random !== 4'd15) begin bad++; $display("FAIL rnd_wrap got=%0d want=15", random); end
        wired_we = 1'b1;
        cyc();
        a = mk(19'h00300, 8'd1, 1'b0, 20'h00a00, 1'b1, 20'h00a01, 1'b1);
        b = mk(19'h00301, 8'd1, 1'b0, 20'h00b00, 1'b1, 20'h00b01, 1'b1);
        wdata = a; wr_we = 1'b1;
        cyc(); m[15] = a;
        wdata = b; wr_we = 1'b1;
        cyc(); m[14] = b;
        rw_index = 4'd15; #1;
        total++; if (rw_rdata !== a) begin bad++; $display("FAIL wr_first got=%h want=%h", rw_rdata, a); end
        rw_index = 4'd14; #1;
        total++; if (rw_rdata !== b) begin bad++; $display("FAIL wr_second got=%h want=%h", rw_rdata, b); end
        wired = 4'd15; wired_we = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++; if (random !== 4'd15) begin bad++; $display("FAIL rnd_pinned got=%0d want=15", random); end
        end
        wired = 4'd0;
    endtask

    task automatic test_rdw_multi();
        asid = 8'd5;
        wdata = mk(19'h00100, 8'd5, 1'b0, 20'h00222, 1'b1, 20'h00333, 1'b0);
        rw_index = 4'd2; wi_we = 1'b1;
        issue(0, 32'h0020_0000);
        cyc(); m[2] = wdata;
        total++; if (lk_result[RW-1] !== 1'b1) begin bad++; $display("FAIL rdw_miss got=%b want=1", lk_result[RW-1]); end
        issue(0, 32'h0020_0000);
        cyc();
        total++; if (lk_result[RW-1:0] !== {1'b0, 4'd2, 20'h00222, 3'd2, 1'b0, 1'b1}) begin
            bad++; $display("FAIL rdw_hit got=%h want=%h", lk_result[RW-1:0], {1'b0, 4'd2, 20'h00222, 3'd2, 1'b0, 1'b1});
        end
        total++; if (multi_hit !== 1'b0) begin bad++; $display("FAIL multi_clear got=%b want=0", multi_hit); end
        wdata = mk(19'h00200, 8'd7, 1'b1, 20'h00111, 1'b1, 20'h00112, 1'b1);
        rw_index = 4'd1; wi_we = 1'b1;
        cyc(); m[1] = wdata;
        wdata = mk(19'h00200, 8'd7, 1'b1, 20'h00666, 1'b1, 20'h00667, 1'b1);
        rw_index = 4'd6; wi_we = 1'b1;
        cyc(); m[6] = wdata;
        issue(0, 32'h0040_0000);
        cyc();
        total++; if (lk_result[RW-1:0] !== {1'b0, 4'd1, 20'h00111, 3'd2, 1'b0, 1'b1}) begin
            bad++; $display("FAIL dup_lowest got=%h want=%h", lk_result[RW-1:0], {1'b0, 4'd1, 20'h00111, 3'd2, 1'b0, 1'b1});
        end
        total++; if (multi_hit !== 1'b1) begin bad++; $display("FAIL dup_multi got=%b want=1", multi_hit); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        wdata = mk(19'h00200, 8'd9, 1'b1, 20'h00999, 1'b1, 20'h00aaa, 1'b1);
        rw_index = 4'd0; wi_we = 1'b1;
        cyc(); model_flush(); m[0] = wdata;
        total++; if (multi_hit !== 1'b0) begin bad++; $display("FAIL flush_multi got=%b want=0", multi_hit); end
        total++; if (rw_rdata !== wdata) begin bad++; $display("FAIL flush_write got=%h want=%h", rw_rdata, wdata); end
        rw_index = 4'd1; #1;
        total++; if (rw_rdata.v0 !== 1'b0 || rw_rdata.v1 !== 1'b0 || rw_rdata.g !== 1'b0 || rw_rdata.vpn2 !== 19'h00200) begin
            bad++; $display("FAIL flush_clear got=%h want=v0/v1/g=0 vpn2=00200", rw_rdata);
        end
        asid = 8'd3;
        issue(0, 32'h0040_0000);
        cyc();
        total++; if (lk_result[RW-1:0] !== {1'b0, 4'd0, 20'h00999, 3'd2, 1'b0, 1'b1}) begin
            bad++; $display("FAIL flush_only0 got=%h want=%h", lk_result[RW-1:0], {1'b0, 4'd0, 20'h00999, 3'd2, 1'b0, 1'b1});
        end
        total++; if (multi_hit !== 1'b0) begin bad++; $display("FAIL flush_nomulti got=%b want=0", multi_hit); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vas [4];
        vas[0] = 32'h0008_1000; vas[1] = 32'h0020_0000; vas[2] = 32'h0040_0000; vas[3] = 32'h1234_5000;
        asid = 8'd5;
        for (int c = 0; c < 4; c++) begin
            issue(0, vas[c]);
            issue(1, vas[(c + 1) % 4]);
            cyc();
        end
        cyc();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        asid = 8'd5;
        issue(0, 32'h0008_1000);
        issue(1, 32'h0040_0000);
        cyc();
        total++; if (lk_rsp_valid !== 2'b11) begin bad++; $display("FAIL mid_valid got=%b want=11", lk_rsp_valid); end
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        for (int i = 0; i < ENTRIES; i++) m[i] = '0;
        total++; if (lk_rsp_valid !== 2'b00 || lk_result !== '0) begin
            bad++; $display("FAIL mid_reset got=%b/%h want=00/0", lk_rsp_valid, lk_result);
        end
        total++; if (random !== 4'd15 || multi_hit !== 1'b0) begin
            bad++; $display("FAIL mid_state got=%0d/%b want=15/0", random, multi_hit);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write_lookup();
        test_asid_global();
        test_probe();
        test_random();
        test_rdw_multi();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
